ddr3_axi_pattern_chk: RTL and testbench

- AXI4 master traffic generator and checker that drives the DDR3 AXI slave port (inport_*) of the controller top.
- Writes a deterministic address-derived pattern over a region in fixed-length INCR bursts, reads it back, and compares every beat.
- Used for board bring-up and as the self-test source in the memory subsystem.
- Only one AXI transaction is outstanding at a time.

---
 rtl/ddr3_axi_pattern_chk.sv | 213 +++++++++++++++++++++
 tb/tb_ddr3_axi_pattern_chk.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_axi_pattern_chk.sv
// AXI4 pattern writer/checker for DDR3 bring-up and self-test.
// Writes addr^seed over a region in INCR bursts, reads back, compares.
module ddr3_axi_pattern_chk #(
  parameter int         BURST_LEN = 4,
  parameter logic [3:0] AXI_ID    = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] num_bursts_i,
  input  logic [31:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_count_o,
  output logic [31:0] err_addr_o,
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  output logic        outport_bready_o,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  output logic        outport_rready_o,
  input  logic        outport_awready_i,
  input  logic        outport_wready_i,
  input  logic        outport_arready_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_ADDR = 3'd1;
  localparam logic [2:0] WR_DATA = 3'd2;
  localparam logic [2:0] WR_RESP = 3'd3;
  localparam logic [2:0] RD_ADDR = 3'd4;
  localparam logic [2:0] RD_DATA = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [31:0] BURST_BYTES = 32'(4 * BURST_LEN);

  logic [2:0]  state;
  logic [31:0] base_r;
  logic [15:0] num_r;
  logic [31:0] seed_r;
  logic [31:0] burst_addr;
  logic [31:0] cur_addr;
  logic [15:0] burst_idx;
  logic [7:0]  beat;
  logic        pass_r;
  logic [15:0] err_cnt;
  logic [31:0] err_addr;

  logic        last_beat;
  logic        last_burst;
  logic        err_hit;
  logic [31:0] err_at;

  assign last_beat  = (beat == LAST_BEAT);
  assign last_burst = (burst_idx == num_r - 16'd1);

  assign busy_o      = (state != IDLE) && (state != DONE);
  assign done_o      = (state == DONE);
  assign pass_o      = done_o ? (err_cnt == 16'd0) : pass_r;
  assign err_count_o = err_cnt;
  assign err_addr_o  = err_addr;

  assign outport_awvalid_o = (state == WR_ADDR);
  assign outport_awaddr_o  = burst_addr;
  assign outport_awid_o    = AXI_ID;
  assign outport_awlen_o   = LAST_BEAT;
  assign outport_awburst_o = 2'b01;

  assign outport_wvalid_o = (state == WR_DATA);
  assign outport_wdata_o  = cur_addr ^ seed_r;
  assign outport_wstrb_o  = 4'hF;
  assign outport_wlast_o  = (state == WR_DATA) && last_beat;
  assign outport_bready_o = (state == WR_RESP);

  assign outport_arvalid_o = (state == RD_ADDR);
  assign outport_araddr_o  = burst_addr;
  assign outport_arid_o    = AXI_ID;
  assign outport_arlen_o   = LAST_BEAT;
  assign outport_arburst_o = 2'b01;
  assign outport_rready_o  = (state == RD_DATA);

  // One error per bad B response or per read beat failing any check.
  always_comb begin
    err_hit = 1'b0;
    err_at  = burst_addr;
    if ((state == WR_RESP) && outport_bvalid_i &&
        ((outport_bresp_i != 2'b00) || (outport_bid_i != AXI_ID))) begin
      err_hit = 1'b1;
    end
    if ((state == RD_DATA) && outport_rvalid_i &&
        ((outport_rdata_i != (cur_addr ^ seed_r)) ||
         (outport_rresp_i != 2'b00) ||
         (outport_rid_i != AXI_ID) ||
         (outport_rlast_i != last_beat))) begin
      err_hit = 1'b1;
      err_at  = cur_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      base_r     <= '0;
      num_r      <= '0;
      seed_r     <= '0;
      burst_addr <= '0;
      cur_addr   <= '0;
      burst_idx  <= '0;
      beat       <= '0;
      pass_r     <= 1'b0;
      err_cnt    <= '0;
      err_addr   <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (start_i) begin
            base_r     <= base_addr_i;
            num_r      <= num_bursts_i;
            seed_r     <= seed_i;
            burst_addr <= base_addr_i;
            burst_idx  <= '0;
            beat       <= '0;
            pass_r     <= 1'b0;
            err_cnt    <= '0;
            err_addr   <= '0;
            state      <= (num_bursts_i == 16'd0) ? DONE : WR_ADDR;
          end
        end
        (state == WR_ADDR): begin
          if (outport_awready_i) begin
            cur_addr <= burst_addr;
            beat     <= '0;
            state    <= WR_DATA;
          end
        end
        (state == WR_DATA): begin
          if (outport_wready_i) begin
            cur_addr <= cur_addr + 32'd4;
            if (last_beat) state <= WR_RESP;
            else beat <= beat + 8'd1;
          end
        end
        (state == WR_RESP): begin
          if (outport_bvalid_i) begin
            if (last_burst) begin
              burst_addr <= base_r;
              burst_idx  <= '0;
              state      <= RD_ADDR;
            end else begin
              burst_addr <= burst_addr + BURST_BYTES;
              burst_idx  <= burst_idx + 16'd1;
              state      <= WR_ADDR;
            end
          end
        end
        (state == RD_ADDR): begin
          if (outport_arready_i) begin
            cur_addr <= burst_addr;
            beat     <= '0;
            state    <= RD_DATA;
          end
        end
        (state == RD_DATA): begin
          // Burst length is ours to track; rlast is only checked.
          if (outport_rvalid_i) begin
            cur_addr <= cur_addr + 32'd4;
            if (!last_beat) begin
              beat <= beat + 8'd1;
            end else if (last_burst) begin
              state <= DONE;
            end else begin
              burst_addr <= burst_addr + BURST_BYTES;
              burst_idx  <= burst_idx + 16'd1;
              state      <= RD_ADDR;
            end
          end
        end
        (state == DONE): begin
          pass_r <= (err_cnt == 16'd0);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (err_hit) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (err_cnt == 16'd0) err_addr <= err_at;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_axi_pattern_chk.sv
// Bench for ddr3_axi_pattern_chk: behavioural AXI slave with
// memory, stall and fault injection, plus expected-result model.
`timescale 1ns/1ps
module tb_ddr3_axi_pattern_chk;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_bursts;
  logic [31:0] seed;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] err_addr;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid, wready, wlast;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bready, bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rready, rvalid, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;

  int tests = 0;
  int fails = 0;

  // slave configuration
  bit          stall_en, corrupt_en, bresp_bad, ridbad_en;
  logic [31:0] cfg_base, cfg_seed, corrupt_addr, ridbad_addr;

  // slave observations and model
  int          n_aw, n_w, n_b, n_ar, n_r;
  bit          any_valid, aw_open, b_pend, r_open;
  bit          aw_hold, w_hold, ar_hold;
  logic [31:0] aw_ha, ar_ha, w_hd;
  logic        w_hl;
  int          exp_errs;
  logic [31:0] exp_eaddr;
  logic [31:0] mem [logic [31:0]];

  ddr3_axi_pattern_chk #(.BURST_LEN(BL), .AXI_ID(4'd0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .base_addr_i(base_addr), .num_bursts_i(num_bursts),
    .seed_i(seed),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(err_count), .err_addr_o(err_addr),
    .outport_awvalid_o(awvalid), .outport_awaddr_o(awaddr),
    .outport_awid_o(awid), .outport_awlen_o(awlen),
    .outport_awburst_o(awburst),
    .outport_wvalid_o(wvalid), .outport_wdata_o(wdata),
    .outport_wstrb_o(wstrb), .outport_wlast_o(wlast),
    .outport_bready_o(bready),
    .outport_arvalid_o(arvalid), .outport_araddr_o(araddr),
    .outport_arid_o(arid), .outport_arlen_o(arlen),
    .outport_arburst_o(arburst),
    .outport_rready_o(rready),
    .outport_awready_i(awready), .outport_wready_i(wready),
    .outport_arready_i(arready),
    .outport_bvalid_i(bvalid), .outport_bresp_i(bresp),
    .outport_bid_i(bid),
    .outport_rvalid_i(rvalid), .outport_rdata_i(rdata),
    .outport_rresp_i(rresp), .outport_rid_i(rid),
    .outport_rlast_i(rlast)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic note_err(input logic [31:0] a);
    if (exp_errs == 0) exp_eaddr = a;
    exp_errs++;
  endtask

  function automatic bit stall_pick();
    return stall_en ? ($urandom_range(0, 2) != 0) : 1'b0;
  endfunction

  // Slave: decides inputs at negedge; handshake happens at next posedge.
  initial begin : slave
    logic [31:0] a, d;
    bit bad;
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; bid = 0;
    rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; rvalid = 0;
        aw_open = 0; b_pend = 0; r_open = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0;
        continue;
      end
      if (awvalid || wvalid || arvalid) any_valid = 1;

      bvalid = b_pend;
      bresp = (bresp_bad && n_b == 0) ? 2'b10 : 2'b00;
      bid = 4'd0;
      if (bvalid && bready) begin
        if (bresp != 2'b00) note_err(cfg_base + 32'(n_b * 4 * BL));
        n_b++;
        b_pend = 0;
      end

      if (w_hold) begin
        tests++;
        if (!wvalid || wdata !== w_hd || wlast !== w_hl) begin
          fails++;
          $display("FAIL w_stable: v=%b d=%h l=%b need d=%h l=%b",
                   wvalid, wdata, wlast, w_hd, w_hl);
        end
        w_hold = 0;
      end
      wready = !stall_pick();
      if (wvalid) begin
        tests++;
        if (!aw_open) begin
          fails++;
          $display("FAIL w_before_aw: wvalid=1 with no open AW");
        end
      end
      if (wvalid && wready && aw_open) begin
        a = cfg_base + 32'(4 * n_w);
        tests++;
        if (wdata !== (a ^ cfg_seed) || wstrb !== 4'hF ||
            wlast !== ((n_w % BL) == BL - 1)) begin
          fails++;
          $display("FAIL w_beat %0d: d=%h l=%b s=%h need d=%h l=%b",
                   n_w, wdata, wlast, wstrb, a ^ cfg_seed,
                   (n_w % BL) == BL - 1);
        end
        mem[a] = wdata;
        n_w++;
        if (n_w % BL == 0) begin
          aw_open = 0;
          b_pend = 1;
        end
      end else if (wvalid && !wready) begin
        w_hold = 1; w_hd = wdata; w_hl = wlast;
      end

      if (aw_hold) begin
        tests++;
        if (!awvalid || awaddr !== aw_ha) begin
          fails++;
          $display("FAIL aw_stable: v=%b a=%h need a=%h",
                   awvalid, awaddr, aw_ha);
        end
        aw_hold = 0;
      end
      awready = !stall_pick();
      if (awvalid && awready) begin
        tests++;
        if (awaddr !== cfg_base + 32'(n_aw * 4 * BL) ||
            awlen !== 8'(BL - 1) || awburst !== 2'b01 ||
            awid !== 4'd0) begin
          fails++;
          $display("FAIL aw %0d: a=%h len=%0d bu=%b id=%h need a=%h",
                   n_aw, awaddr, awlen, awburst, awid,
                   cfg_base + 32'(n_aw * 4 * BL));
        end
        n_aw++;
        aw_open = 1;
      end else if (awvalid) begin
        aw_hold = 1; aw_ha = awaddr;
      end

      rvalid = r_open && !stall_pick();
      rdata = 0; rid = 0; rlast = 0; rresp = 0;
      if (rvalid) begin
        a = cfg_base + 32'(4 * n_r);
        d = mem.exists(a) ? mem[a] : ~(a ^ cfg_seed);
        bad = !mem.exists(a);
        if (corrupt_en && a == corrupt_addr) begin
          d = d ^ 32'h1;
          bad = 1;
        end
        if (ridbad_en && a == ridbad_addr) begin
          rid = 4'h3;
          bad = 1;
        end
        rdata = d;
        rlast = ((n_r % BL) == BL - 1);
        tests++;
        if (!rready) begin
          fails++;
          $display("FAIL rready: got %b need 1", rready);
        end else begin
          if (bad) note_err(a);
          n_r++;
          if (n_r % BL == 0) r_open = 0;
        end
      end

      if (ar_hold) begin
        tests++;
        if (!arvalid || araddr !== ar_ha) begin
          fails++;
          $display("FAIL ar_stable: v=%b a=%h need a=%h",
                   arvalid, araddr, ar_ha);
        end
        ar_hold = 0;
      end
      arready = !stall_pick();
      if (arvalid && arready) begin
        tests++;
        if (araddr !== cfg_base + 32'(n_ar * 4 * BL) ||
            arlen !== 8'(BL - 1) || arburst !== 2'b01 ||
            arid !== 4'd0) begin
          fails++;
          $display("FAIL ar %0d: a=%h len=%0d bu=%b id=%h need a=%h",
                   n_ar, araddr, arlen, arburst, arid,
                   cfg_base + 32'(n_ar * 4 * BL));
        end
        n_ar++;
        r_open = 1;
      end else if (arvalid) begin
        ar_hold = 1; ar_ha = araddr;
      end
    end
  end

  task automatic run_test(input string name, input logic [31:0] b,
                          input int num, input logic [31:0] s,
                          input bit stl, input bit poke);
    int cyc;
    logic [31:0] want_ea;
    bit want_pass;
    cfg_base = b; cfg_seed = s; stall_en = stl;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    any_valid = 0; exp_errs = 0; exp_eaddr = 0;
    mem.delete();
    @(negedge clk); #1;
    base_addr = b; num_bursts = 16'(num); seed = s; start = 1;
    @(negedge clk); #1;
    start = 0;
    // inputs are sampled at start only
    base_addr = ~b; seed = ~s; num_bursts = 16'hFFFF;
    cyc = 0;
    while (!done && cyc < 4000) begin
      start = poke && (cyc == 5);
      @(negedge clk); #1;
      cyc++;
    end
    start = 0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s done_timeout: no done after %0d cycles", name, cyc);
      return;
    end
    want_pass = (exp_errs == 0);
    want_ea = (exp_errs == 0) ? 32'h0 : exp_eaddr;
    tests++;
    if (busy !== 1'b0 || pass !== want_pass ||
        err_count !== 16'(exp_errs) || err_addr !== want_ea) begin
      fails++;
      $display("FAIL %s result: busy=%b pass=%b cnt=%0d ea=%h need 0 %b %0d %h",
               name, busy, pass, err_count, err_addr,
               want_pass, exp_errs, want_ea);
    end
    tests++;
    if (n_aw != num || n_w != num * BL || n_b != num ||
        n_ar != num || n_r != num * BL) begin
      fails++;
      $display("FAIL %s counts: aw=%0d w=%0d b=%0d ar=%0d r=%0d need %0d bursts",
               name, n_aw, n_w, n_b, n_ar, n_r, num);
    end
    if (num == 0) begin
      tests++;
      if (cyc != 0 || any_valid) begin
        fails++;
        $display("FAIL %s zero: done at +%0d valid=%b need +0 valid=0",
                 name, cyc, any_valid);
      end
    end
    @(negedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== want_pass ||
        err_count !== 16'(exp_errs) || err_addr !== want_ea) begin
      fails++;
      $display("FAIL %s hold: done=%b busy=%b pass=%b cnt=%0d ea=%h need 0 0 %b %0d %h",
               name, done, busy, pass, err_count, err_addr,
               want_pass, exp_errs, want_ea);
    end
  endtask

  task automatic clear_faults();
    corrupt_en = 0; bresp_bad = 0; ridbad_en = 0;
    corrupt_addr = 0; ridbad_addr = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; base_addr = 0; num_bursts = 0; seed = 0;
    clear_faults();
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({busy, done, pass, err_count, err_addr, awvalid, wvalid,
         bready, arvalid, rready} !== '0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b pass=%b cnt=%h ea=%h v=%b%b%b%b%b need all 0",
               busy, done, pass, err_count, err_addr,
               awvalid, wvalid, bready, arvalid, rready);
    end
    rst = 0;
  endtask

  task automatic test_ideal();
    clear_faults();
    run_test("ideal", 32'h1000, 2, 32'hA5A5A5A5, 0, 0);
  endtask

  task automatic test_stalls();
    clear_faults();
    run_test("stalls", 32'h1000, 2, 32'hA5A5A5A5, 1, 1);
  endtask

  task automatic test_corrupt();
    clear_faults();
    corrupt_en = 1; corrupt_addr = 32'h1008;
    run_test("corrupt", 32'h1000, 2, 32'hA5A5A5A5, 0, 0);
  endtask

  task automatic test_bresp_rid();
    clear_faults();
    bresp_bad = 1;
    ridbad_en = 1; ridbad_addr = 32'h1014;
    run_test("bresp_rid", 32'h1000, 2, 32'hA5A5A5A5, 1, 0);
  endtask

  task automatic test_zero();
    clear_faults();
    run_test("zero", 32'h4000, 0, 32'h12345678, 0, 0);
  endtask

  task automatic test_wrap();
    clear_faults();
    run_test("wrap", 32'hFFFFFFF8, 1, 32'h0F0F0F0F, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      clear_faults();
      corrupt_en = 1;
      corrupt_addr = 32'h3000 + 32'(4 * $urandom_range(0, 11));
      run_test("random", 32'h3000, $urandom_range(1, 3),
               $urandom, 1, 0);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_faults();
    cfg_base = 32'h2000; cfg_seed = 32'h55AA55AA; stall_en = 0;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    mem.delete();
    @(negedge clk); #1;
    base_addr = 32'h2000; num_bursts = 16'd2; seed = 32'h55AA55AA;
    start = 1;
    @(negedge clk); #1;
    start = 0;
    cyc = 0;
    while (!wvalid && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    tests++;
    if (!wvalid) begin
      fails++;
      $display("FAIL reset_mid wait: wvalid=%b need 1", wvalid);
    end
    rst = 1;
    @(negedge clk); #1;
    tests++;
    if ({busy, done, pass, err_count, err_addr, awvalid, wvalid,
         bready, arvalid, rready} !== '0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b done=%b pass=%b cnt=%h ea=%h v=%b%b%b%b%b need all 0",
               busy, done, pass, err_count, err_addr,
               awvalid, wvalid, bready, arvalid, rready);
    end
    rst = 0;
    @(negedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stalls();
    test_corrupt();
    test_bresp_rid();
    test_zero();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
